uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Byte-level command controller that sits directly behind the UART receiver. It consumes `rx_data`/`rx_valid` bytes, parses fixed-format read/write frames, and maintains a bank of 8-bit configuration registers. Each frame produces one response byte on a ready/valid TX port, which feeds the UART transmitter. It is the single point through which a host configures the design over the serial link.

## Interface
Parameters:
- `NREGS`, 8: number of 8-bit configuration registers (1..128).
- `TIMEOUT_CYCLES`, 50000: maximum idle clock cycles between bytes inside a frame (1 ms at 50 MHz).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `rx_data`, in, 8: received byte; qualified by `rx_valid`.
- `rx_valid`, in, 1: one-cycle strobe per received byte.
- `tx_data`, out, 8: response byte.
- `tx_valid`, out, 1: response available; held until accepted.
- `tx_ready`, in, 1: transmitter accepts the byte when `tx_valid && tx_ready`.
- `cfg_regs`, out, 8*NREGS: flat register bank; register i occupies bits [8i+7:8i].
- `wr_strobe`, out, 1: one-cycle pulse when a register has just been written.
- `wr_addr`, out, 7: address of the last write; valid with `wr_strobe`.
- `err_count`, out, 8: saturating error counter.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- Frame formats:
  - Write: `A5`, CMD, DATA, CHK, where CMD[7]=1, ADDR=CMD[6:0] and CHK = CMD ^ DATA.
  - Read: `A5`, CMD, CHK, where CMD[7]=0 and CHK = ~CMD.
- FSM states: IDLE, CMD, DATA, CHK, RESP.
  - IDLE: a byte equal to `A5` moves to CMD. Any other byte is ignored, with no error.
  - CMD: latch the byte. CMD[7]=1 goes to DATA; CMD[7]=0 goes to CHK.
  - DATA: latch the byte, go to CHK.
  - CHK: compare against the expected value.
    - Good write with ADDR<NREGS: write the register, respond ACK `06`.
    - Good read with ADDR<NREGS: respond with the register value.
    - Bad checksum or ADDR>=NREGS: respond NAK `15`, increment `err_count`, leave the registers unchanged.
    - All cases go to RESP.
  - RESP: drive `tx_valid` with the latched response. On `tx_valid && tx_ready`, go to IDLE.
- Timeout:
  - The counter clears on every accepted byte and runs only in CMD/DATA/CHK.
  - When it reaches TIMEOUT_CYCLES-1 without a byte, go to IDLE and increment `err_count`. No response is sent.
  - If `rx_valid` arrives in the same cycle as the timeout, the byte wins and the timeout is ignored.
- Overrun: `rx_valid` during RESP drops the byte and increments `err_count`. The state is unchanged.
- `err_count` saturates at 255. Simultaneous error events in one cycle count once.
- Reset values: state IDLE; `cfg_regs` all zero; `tx_valid`=0, `tx_data`=0, `wr_strobe`=0, `wr_addr`=0, `err_count`=0, `busy`=0. Reset mid-frame aborts the frame and sends no response.

## Timing
- Bytes are consumed in the cycle `rx_valid` is high. There is no input backpressure.
- CHK byte in cycle N, then in cycle N+1:
  - `cfg_regs` shows the new value.
  - `wr_strobe` is high for exactly one cycle (writes only).
  - `tx_valid` is high with the response.
- `tx_data` is stable while `tx_valid && !tx_ready`.
- After the handshake cycle, `busy`=0 on the next cycle. A new `A5` is accepted from that cycle onward.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last accepted in-frame byte.

## Structure
- Package `uart_cmd_pkg` holds:
  - Constants SYNC_BYTE=`A5`, ACK_BYTE=`06`, NAK_BYTE=`15`.
  - The state enum `cmd_state_t`.
- Sub-module `uart_cmd_regbank` holds the NREGS×8 storage, with a write port (en, addr, data), a combinational read port, and the flat `cfg_regs` output.
- The FSM, timeout counter and error counter live in the top.

## Test plan
- Write `A5 83 5A D9` with `tx_ready`=1 → reg3=`5A`, one `wr_strobe` pulse with `wr_addr`=3, `tx_data`=`06`, `err_count`=0.
- After that write, read `A5 03 FC` → `tx_data`=`5A` one cycle after CHK, no `wr_strobe`.
- Write `A5 81 11 00` (bad CHK) → `tx_data`=`15`, reg1 unchanged, `err_count`=1. Write `A5 8A 01 8B` (ADDR 10 ≥ 8) → NAK, `err_count`=2.
- Send `A5 82` then no byte for 50000 cycles → IDLE, `busy`=0, `err_count`+1, no `tx_valid`. Repeat with the DATA byte arriving exactly on the timeout cycle → frame continues.
- Hold `tx_ready`=0 for 20 cycles after a response and inject 2 `rx_valid` bytes → `tx_data` stable, bytes dropped, `err_count`+2, handshake completes when `tx_ready` rises. Separately, inject 300 errors → `err_count`=255.
- Assert `rst` between the DATA and CHK bytes → all outputs return to reset values. The following CHK byte is ignored because the state is IDLE and the byte is not `A5`.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM state type for the UART command controller.
// Holds the frame marker, response bytes and the cmd_state_t enum.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_CHK,
        S_RESP
    } cmd_state_t;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte stream bundle between the UART PHY side and the command controller.
// master: host/PHY side (drives rx_*, tx_ready); slave: controller.
interface uart_cmd_ctrl_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

endinterface

// File: rtl/uart_cmd_regbank.sv
// NREGS x 8-bit configuration storage with one synchronous write port.
// Ports: clk, rst, wr_en_i/wr_addr_i/wr_data_i, rd_addr_i -> rd_data_o, cfg_regs_o.
module uart_cmd_regbank #(
    parameter int NREGS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [6:0]           wr_addr_i,
    input  logic [7:0]           wr_data_i,
    input  logic [6:0]           rd_addr_i,
    output logic [7:0]           rd_data_o,
    output logic [8*NREGS-1:0]   cfg_regs_o
);

    logic [8*NREGS-1:0] regs_q;

    logic wr_ok;
    logic rd_ok;

    // Addresses are 7 bits wide but the bank may be smaller.
    assign wr_ok = {1'b0, wr_addr_i} < 8'(NREGS);
    assign rd_ok = {1'b0, rd_addr_i} < 8'(NREGS);

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else if (wr_en_i && wr_ok) begin
            regs_q[8*int'(wr_addr_i) +: 8] <= wr_data_i;
        end
    end

    assign rd_data_o  = rd_ok ? regs_q[8*int'(rd_addr_i) +: 8] : 8'h00;
    assign cfg_regs_o = regs_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser behind the UART RX: read/write config registers, one reply byte.
// Ports: clk, rst, bus (rx/tx stream), cfg_regs, wr_strobe, wr_addr, err_count, busy.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int NREGS          = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst,
    uart_cmd_ctrl_if.slave      bus,
    output logic [8*NREGS-1:0]  cfg_regs,
    output logic                wr_strobe,
    output logic [6:0]          wr_addr,
    output logic [7:0]          err_count,
    output logic                busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    cmd_state_t state_q, state_d;

    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [6:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic       err_inc;
    logic       we;
    logic       tmo_hit;
    logic       addr_ok;
    logic       chk_ok;
    logic [7:0] rd_data;

    uart_cmd_regbank #(
        .NREGS(NREGS)
    ) u_regbank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (we),
        .wr_addr_i (cmd_q[6:0]),
        .wr_data_i (data_q),
        .rd_addr_i (cmd_q[6:0]),
        .rd_data_o (rd_data),
        .cfg_regs_o(cfg_regs)
    );

    assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES - 1);
    assign addr_ok = {1'b0, cmd_q[6:0]} < 8'(NREGS);

    // Writes check CMD^DATA, reads check ~CMD.
    assign chk_ok = cmd_q[7] ? (bus.rx_data == (cmd_q ^ data_q))
                             : (bus.rx_data == ~cmd_q);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        tx_data_d   = tx_data_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        tmo_d       = '0;
        err_inc     = 1'b0;
        we          = 1'b0;

        if (state_q == S_CMD || state_q == S_DATA || state_q == S_CHK) begin
            tmo_d = bus.rx_valid ? '0 : tmo_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (bus.rx_valid) begin
                    cmd_d   = bus.rx_data;
                    state_d = bus.rx_data[7] ? S_DATA : S_CHK;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    err_inc = 1'b1;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    data_d  = bus.rx_data;
                    state_d = S_CHK;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    err_inc = 1'b1;
                end
            end
            S_CHK: begin
                if (bus.rx_valid) begin
                    state_d = S_RESP;
                    if (chk_ok && addr_ok) begin
                        if (cmd_q[7]) begin
                            we          = 1'b1;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = cmd_q[6:0];
                            tx_data_d   = ACK_BYTE;
                        end else begin
                            tx_data_d = rd_data;
                        end
                    end else begin
                        tx_data_d = NAK_BYTE;
                        err_inc   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    err_inc = 1'b1;
                end
            end
            S_RESP: begin
                // No input backpressure: a byte here is lost.
                if (bus.rx_valid) begin
                    err_inc = 1'b1;
                end
                if (bus.tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            data_q      <= '0;
            tx_data_q   <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            err_q       <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            tx_data_q   <= tx_data_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = state_q == S_RESP;
    assign wr_strobe    = wr_strobe_q;
    assign wr_addr      = wr_addr_q;
    assign err_count    = err_q;
    assign busy         = state_q != S_IDLE;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frames, NAKs, timeout, overrun, reset.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_uart_cmd_ctrl;

    localparam int NREGS = 8;
    localparam int TMO   = 100;

    logic                clk;
    logic                rst;
    logic [8*NREGS-1:0]  cfg_regs;
    logic                wr_strobe;
    logic [6:0]          wr_addr;
    logic [7:0]          err_count;
    logic                busy;

    int n_tests;
    int n_fail;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(
        .NREGS         (NREGS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cfg_regs (cfg_regs),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .err_count(err_count),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Byte is consumed on the posedge after it is driven; returns at the
    // following negedge, i.e. one cycle after the consuming cycle.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] reg_at(input int i);
        return cfg_regs[8*i +: 8];
    endfunction

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_busy", 64'(busy), 64'd0);
        check("rst_txv", 64'(bus.tx_valid), 64'd0);
        check("rst_txd", 64'(bus.tx_data), 64'h00);
        check("rst_err", 64'(err_count), 64'd0);
        check("rst_regs", cfg_regs, 64'd0);
        check("rst_wrs", 64'(wr_strobe), 64'd0);
        check("rst_wra", 64'(wr_addr), 64'd0);

        // Good write of reg3.
        send_byte(8'hA5);
        send_byte(8'h83);
        send_byte(8'h5A);
        send_byte(8'hD9);
        check("wr_txv", 64'(bus.tx_valid), 64'd1);
        check("wr_txd", 64'(bus.tx_data), 64'h06);
        check("wr_strobe", 64'(wr_strobe), 64'd1);
        check("wr_addr", 64'(wr_addr), 64'd3);
        check("wr_reg3", 64'(reg_at(3)), 64'h5A);
        check("wr_err", 64'(err_count), 64'd0);
        @(negedge clk);
        check("wr_strobe_1cyc", 64'(wr_strobe), 64'd0);
        check("wr_busy_after", 64'(busy), 64'd0);
        check("wr_txv_after", 64'(bus.tx_valid), 64'd0);

        // Read back reg3.
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'hFC);
        check("rd_txv", 64'(bus.tx_valid), 64'd1);
        check("rd_txd", 64'(bus.tx_data), 64'h5A);
        check("rd_nostrobe", 64'(wr_strobe), 64'd0);
        @(negedge clk);
        check("rd_busy_after", 64'(busy), 64'd0);

        // Bad checksum.
        send_byte(8'hA5);
        send_byte(8'h81);
        send_byte(8'h11);
        send_byte(8'h00);
        check("badchk_txd", 64'(bus.tx_data), 64'h15);
        check("badchk_reg1", 64'(reg_at(1)), 64'h00);
        check("badchk_err", 64'(err_count), 64'd1);
        check("badchk_nostrobe", 64'(wr_strobe), 64'd0);
        @(negedge clk);

        // Address out of range.
        send_byte(8'hA5);
        send_byte(8'h8A);
        send_byte(8'h01);
        send_byte(8'h8B);
        check("badaddr_txd", 64'(bus.tx_data), 64'h15);
        check("badaddr_err", 64'(err_count), 64'd2);
        check("badaddr_nostrobe", 64'(wr_strobe), 64'd0);
        check("badaddr_regs", cfg_regs, 64'h0000_005A_0000_0000 >> 8);
        @(negedge clk);

        // Timeout in DATA: last byte consumed in cycle 0, fires in cycle TMO.
        send_byte(8'hA5);
        send_byte(8'h82);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_busy_edge", 64'(busy), 64'd1);
        check("tmo_err_edge", 64'(err_count), 64'd2);
        @(negedge clk);
        check("tmo_busy", 64'(busy), 64'd0);
        check("tmo_err", 64'(err_count), 64'd3);
        check("tmo_txv", 64'(bus.tx_valid), 64'd0);

        // Data byte lands exactly on the timeout cycle: frame continues.
        send_byte(8'hA5);
        send_byte(8'h82);
        repeat (TMO - 2) @(negedge clk);
        send_byte(8'h5A);
        check("race_busy", 64'(busy), 64'd1);
        check("race_err", 64'(err_count), 64'd3);
        send_byte(8'hD8);
        check("race_txd", 64'(bus.tx_data), 64'h06);
        check("race_reg2", 64'(reg_at(2)), 64'h5A);
        check("race_wra", 64'(wr_addr), 64'd2);
        @(negedge clk);

        // Overrun while response is stalled.
        bus.tx_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hFD);
        check("ovr_txv0", 64'(bus.tx_valid), 64'd1);
        check("ovr_txd0", 64'(bus.tx_data), 64'h5A);
        for (int i = 0; i < 20; i++) begin
            bus.rx_data  = 8'hA5;
            bus.rx_valid = (i == 5 || i == 12);
            @(negedge clk);
            check("ovr_hold", {bus.tx_valid, bus.tx_data}, 64'h15A);
        end
        bus.rx_valid = 1'b0;
        check("ovr_err", 64'(err_count), 64'd5);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        check("ovr_busy_after", 64'(busy), 64'd0);
        check("ovr_err_after", 64'(err_count), 64'd5);

        // Saturation of the error counter.
        bus.tx_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'hFF);
        check("sat_txd", 64'(bus.tx_data), 64'h00);
        bus.rx_valid = 1'b1;
        repeat (200) @(negedge clk);
        check("sat_mid", 64'(err_count), 64'd205);
        repeat (100) @(negedge clk);
        bus.rx_valid = 1'b0;
        check("sat_err", 64'(err_count), 64'd255);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        check("sat_busy_after", 64'(busy), 64'd0);

        // Reset between DATA and CHK.
        send_byte(8'hA5);
        send_byte(8'h83);
        send_byte(8'h77);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_err", 64'(err_count), 64'd0);
        check("mrst_regs", cfg_regs, 64'd0);
        check("mrst_txd", 64'(bus.tx_data), 64'h00);
        send_byte(8'hF4);
        check("mrst_chk_busy", 64'(busy), 64'd0);
        check("mrst_chk_txv", 64'(bus.tx_valid), 64'd0);
        check("mrst_chk_wrs", 64'(wr_strobe), 64'd0);
        check("mrst_chk_regs", cfg_regs, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
